// File: rtl/uart_rx_param_if.sv
// Bus-side receive port of uart_rx_param: FIFO head, pop strobe, error flags and fill level.
// rx_valid is the head-valid and read is the ready: one word transfers on each clock edge
// where both are high. read while rx_valid is low is ignored. rx_data and the error flags
// are stable whenever rx_valid is high.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 3
);
  logic                 read;
  logic                 err_clr;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 overrun;
  logic [CNT_W-1:0]     fifo_count;

  modport master (
    input  read, err_clr,
    output rx_valid, rx_data, rx_parity_err, rx_frame_err, overrun, fifo_count
  );

  modport slave (
    output read, err_clr,
    input  rx_valid, rx_data, rx_parity_err, rx_frame_err, overrun, fifo_count
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised rx, configurable parity and stop bits, break
// handling, first-word-fall-through receive FIFO with sticky overrun and registered irq.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clk_div,
  input  logic [1:0]  parity_mode,
  input  logic        stop2,
  input  logic        rx,
  input  logic        irq_en,
  output logic        irq,
  output logic [2:0]  state_dbg,
  uart_rx_param_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = 4;
  localparam int W     = DATA_BITS + 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 second_q, second_d;
  logic                 push, push_ferr;

  logic        rx_meta, rxs;
  logic [31:0] div, half;
  logic        parity_en, parity_odd, bit_end, half_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign div        = (clk_div < 32'd2) ? 32'd2 : clk_div;
  assign half       = div >> 1;
  assign parity_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign parity_odd = (parity_mode == 2'b10);
  assign bit_end    = (cnt_q == div - 32'd1);
  assign half_end   = (cnt_q == half - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      second_q <= second_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    idx_d     = idx_q;
    data_d    = data_q;
    perr_d    = perr_q;
    second_d  = second_q;
    push      = 1'b0;
    push_ferr = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        // Mid-start-bit recheck rejects short glitches without pushing anything.
        if (half_end) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d  = DATA;
            idx_d    = '0;
            data_d   = '0;
            perr_d   = 1'b0;
            second_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d  = '0;
          data_d = {rxs, data_q[DATA_BITS-1:1]};
          if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = parity_en ? PARITY : STOP;
          else                                idx_d   = idx_q + IDX_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          perr_d  = ((^data_q) ^ rxs) != parity_odd;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!rxs) begin
            push      = 1'b1;
            push_ferr = 1'b1;
            state_d   = BREAK_WAIT;
          end else if (stop2 && !second_q) begin
            second_d = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full, pop, do_push, ovr_set, overrun_q;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = bus.read && (count_q != '0);
  // A push into a full FIFO is still accepted when the head is popped on the same edge.
  assign do_push = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {data_q, perr_q, push_ferr};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(pop);
      if (ovr_set)          overrun_q <= 1'b1;
      else if (bus.err_clr) overrun_q <= 1'b0;
      irq <= irq_en & ((count_q != '0) | overrun_q);
    end
  end

  assign bus.rx_valid = (count_q != '0);
  assign {bus.rx_data, bus.rx_parity_err, bus.rx_frame_err} = mem[rd_ptr];
  assign bus.overrun    = overrun_q;
  assign bus.fifo_count = count_q;
  assign state_dbg      = state_q;

endmodule
